regfile_dump_reader: RTL and testbench

Debug/read-back engine for the CPU register file: on a `start` pulse it walks a contiguous range of register indices through one register-file read port, captures each value, and streams `(index, data)` words out on a valid/ready interface. It sits beside the register file in the CPU datapath, drives one read-address input, and feeds a debug sink such as a UART transmitter or trace buffer. It never writes the register file.

---
 rtl/regfile_dump_reader.sv | 139 +++++++++++++
 tb/tb_regfile_dump_reader.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks register indices FIRST_REG..LAST_REG through one
// register-file read port and streams (index, data) words on a valid/ready
// interface for a debug sink. The block only reads the register file.
module regfile_dump_reader #(
   parameter int unsigned FIRST_REG = 0,
   parameter int unsigned LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        reset,          // asynchronous, active-low
   input  logic        start,
   input  logic        abort,
   output logic [4:0]  Read_register,
   input  logic [31:0] Read_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_addr,
   output logic [31:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        done
);

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_SEND = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic        valid_q, valid_d;
   logic [4:0]  addr_q, addr_d;
   logic [31:0] data_q, data_d;
   logic        last_q, last_d;

   // State and stream registers; reset drops the stream word immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         idx_q   <= FIRST_IDX;
         valid_q <= 1'b0;
         addr_q  <= 5'd0;
         data_q  <= 32'd0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

   // Next-state logic: abort outranks both the handshake and the DONE step.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      last_d  = last_q;

      unique case (state_q)
         S_IDLE: begin
            idx_d = FIRST_IDX;
            // start wins over a simultaneous abort here, abort is a no-op in IDLE
            if (start) begin
               state_d = S_READ;
            end
         end

         S_READ: begin
            if (abort) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
               idx_d   = FIRST_IDX;
            end else begin
               // Whatever the port returns this cycle (bypassed writes included)
               // is the captured value.
               data_d  = Read_data;
               addr_d  = idx_q;
               last_d  = (idx_q == LAST_IDX);
               valid_d = 1'b1;
               state_d = S_SEND;
            end
         end

         S_SEND: begin
            if (abort) begin
               state_d = S_IDLE;
               valid_d = 1'b0;
               last_d  = 1'b0;
               idx_d   = FIRST_IDX;
            end else if (out_ready) begin
               valid_d = 1'b0;
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  // LAST_IDX <= 31 guarantees this never wraps.
                  idx_d   = idx_q + 5'd1;
                  state_d = S_READ;
               end
            end
         end

         S_DONE: begin
            if (abort) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
            end
            idx_d   = FIRST_IDX;
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
            idx_d   = FIRST_IDX;
            valid_d = 1'b0;
            last_d  = 1'b0;
         end
      endcase
   end

   assign Read_register = idx_q;
   assign out_valid     = valid_q;
   assign out_addr      = addr_q;
   assign out_data      = data_q;
   assign out_last      = last_q;
   assign busy          = (state_q != S_IDLE);
   // An abort landing on the DONE cycle suppresses the completion pulse.
   assign done          = (state_q == S_DONE) && !abort;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for regfile_dump_reader: transaction-level reference model, per-cycle
// compare process, stream scoreboard, directed scenarios and random traffic.
module tb_regfile_dump_reader;

   localparam logic [4:0] FIRST5 = 5'd0;
   localparam logic [4:0] LAST5  = 5'd31;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic        out_ready = 1'b0;
   logic [4:0]  rr;
   logic [31:0] rd;
   logic        out_valid;
   logic [4:0]  out_addr;
   logic [31:0] out_data;
   logic        out_last;
   logic        busy;
   logic        done;

   logic [31:0] rf [32];
   assign rd = rf[rr];

   regfile_dump_reader #(.FIRST_REG(0), .LAST_REG(31)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .Read_register(rr), .Read_data(rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
   );

   // Second instance with a short range 28..31
   logic        start2 = 1'b0;
   logic        abort2 = 1'b0;
   logic        ready2 = 1'b1;
   logic [4:0]  rr2;
   logic [31:0] rd2;
   logic        valid2, last2, busy2, done2;
   logic [4:0]  addr2;
   logic [31:0] data2;
   assign rd2 = rf[rr2];

   regfile_dump_reader #(.FIRST_REG(28), .LAST_REG(31)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .abort(abort2),
      .Read_register(rr2), .Read_data(rd2),
      .out_valid(valid2), .out_ready(ready2), .out_addr(addr2),
      .out_data(data2), .out_last(last2), .busy(busy2), .done(done2)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   // m_busy: a dump is in progress; m_fetch: the next word is being read this
   // cycle; m_valid: a word is on offer; m_fin: final word accepted, completion
   // cycle; m_cur: index currently presented to the register file.
   logic        m_busy = 1'b0, m_fetch = 1'b0, m_valid = 1'b0, m_fin = 1'b0, m_last = 1'b0;
   logic [4:0]  m_cur = FIRST5, m_addr = 5'd0;
   logic [31:0] m_data = 32'd0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_busy <= 1'b0; m_fetch <= 1'b0; m_valid <= 1'b0; m_fin <= 1'b0;
         m_last <= 1'b0; m_addr <= 5'd0; m_data <= 32'd0; m_cur <= FIRST5;
      end else if (!m_busy) begin
         if (start) begin
            m_busy  <= 1'b1;
            m_fetch <= 1'b1;
         end
      end else if (abort) begin
         m_busy <= 1'b0; m_fetch <= 1'b0; m_valid <= 1'b0; m_fin <= 1'b0;
         m_last <= 1'b0; m_cur <= FIRST5;
      end else if (m_fin) begin
         m_busy <= 1'b0; m_fin <= 1'b0; m_cur <= FIRST5;
      end else if (m_fetch) begin
         m_fetch <= 1'b0;
         m_valid <= 1'b1;
         m_addr  <= m_cur;
         m_data  <= rf[m_cur];
         m_last  <= (m_cur == LAST5);
      end else if (out_ready) begin
         m_valid <= 1'b0;
         if (m_cur == LAST5) m_fin <= 1'b1;
         else begin
            m_cur   <= m_cur + 5'd1;
            m_fetch <= 1'b1;
         end
      end
   end

   // ---------------- compare process + stream scoreboard ----------------
   logic [4:0]  sb_next = FIRST5;
   int          nwords = 0;
   int          nlast  = 0;
   logic [31:0] got [32];

   always @(negedge clk) begin
      check("Read_register", 32'(rr), 32'(m_cur));
      check("busy", 32'(busy), 32'(m_busy));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("out_addr", 32'(out_addr), 32'(m_addr));
      check("out_data", out_data, m_data);
      check("out_last", 32'(out_last), 32'(m_last));
      check("done", 32'(done), 32'(m_fin && !abort));
      if (reset && out_valid && out_ready && !abort) begin
         check("stream_order", 32'(out_addr), 32'(sb_next));
         check("stream_data", out_data, rf[out_addr]);
         check("stream_last", 32'(out_last), 32'(out_addr == LAST5));
         if (out_last) nlast++;
         got[out_addr] = out_data;
         nwords++;
         sb_next = out_addr + 5'd1;
      end
      if (!busy) sb_next = FIRST5;
   end

   // Drives one dump (start must already be high for cycle 0). Returns the
   // cycle in which done was seen, or -1 if the dump ended without done.
   task automatic run(input int stall_addr, input int stall_n, input int bs_addr,
                      input int ab_addr, output int dcyc);
      int  cyc;
      int  stalls;
      bit  sp;
      bit  ended;
      cyc = 0; stalls = 0; sp = 1'b0; ended = 1'b0; dcyc = -1;
      while (cyc < 300 && !ended) begin
         tick();
         cyc++;
         start = 1'b0; abort = 1'b0; out_ready = 1'b1;
         if (done) begin
            dcyc = cyc;
            ended = 1'b1;
         end else if (!busy) begin
            ended = 1'b1;
         end else if (out_valid) begin
            if (int'(out_addr) == stall_addr && stalls < stall_n) begin
               out_ready = 1'b0;
               stalls++;
            end
            if (int'(out_addr) == bs_addr && !sp) begin
               start = 1'b1;
               sp = 1'b1;
            end
            if (int'(out_addr) == ab_addr) abort = 1'b1;
         end
      end
      if (!ended) check("run_timeout", 32'd1, 32'd0);
   endtask

   task automatic clear_stats();
      nwords = 0;
      nlast  = 0;
      for (int i = 0; i < 32; i++) got[i] = 32'hdeadbeef;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int dcyc;
      int cyc;
      int w;
      int dc;

      for (int i = 0; i < 32; i++) rf[i] = 32'(i) * 32'h11;
      rf[29] = 32'h3ffc;

      // Reset state
      repeat (3) tick();
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_rr", 32'(rr), 32'd0);
      check("rst_rr2", 32'(rr2), 32'd28);
      reset = 1'b1;
      repeat (10) tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(out_valid), 32'd0);

      // Full dump, no backpressure
      clear_stats();
      start = 1'b1;
      run(99, 0, 99, 99, dcyc);
      check("full_done_cycle", 32'(dcyc), 32'd65);
      check("full_words", 32'(nwords), 32'd32);
      check("full_nlast", 32'(nlast), 32'd1);
      check("full_r0", got[0], 32'h0);
      check("full_r5", got[5], 32'h55);
      check("full_r29", got[29], 32'h3ffc);
      check("full_r31", got[31], 32'h20f);
      tick();

      // Backpressure on addr 3 for 5 cycles
      clear_stats();
      start = 1'b1;
      run(3, 5, 99, 99, dcyc);
      check("bp_done_cycle", 32'(dcyc), 32'd70);
      check("bp_words", 32'(nwords), 32'd32);
      tick();

      // start at word 7 and in the DONE cycle are ignored; start right after done restarts
      clear_stats();
      start = 1'b1;
      run(99, 0, 7, 99, dcyc);
      check("sb_done_cycle", 32'(dcyc), 32'd65);
      check("sb_words", 32'(nwords), 32'd32);
      start = 1'b1;              // still the DONE cycle
      tick();
      check("start_in_done_ignored", 32'(busy), 32'd0);
      clear_stats();
      start = 1'b1;              // one cycle after done
      run(99, 0, 99, 99, dcyc);
      check("restart_done_cycle", 32'(dcyc), 32'd65);
      check("restart_words", 32'(nwords), 32'd32);
      check("restart_first", got[0], 32'h0);
      tick();

      // Abort during SEND of addr 10 with out_ready high
      clear_stats();
      start = 1'b1;
      run(99, 0, 99, 10, dcyc);
      check("abort_no_done", 32'(dcyc), 32'hffffffff);
      check("abort_valid", 32'(out_valid), 32'd0);
      check("abort_words", 32'(nwords), 32'd10);
      check("abort_rr", 32'(rr), 32'd0);
      repeat (4) tick();
      clear_stats();
      start = 1'b1;
      run(99, 0, 99, 99, dcyc);
      check("post_abort_done_cycle", 32'(dcyc), 32'd65);
      check("post_abort_words", 32'(nwords), 32'd32);
      tick();

      // Asynchronous reset mid-dump
      start = 1'b1;
      tick();
      start = 1'b0;
      out_ready = 1'b1;
      repeat (7) tick();
      check("pre_rst_valid", 32'(out_valid), 32'd1);
      check("pre_rst_addr", 32'(out_addr), 32'd3);
      #2 reset = 1'b0;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_addr", 32'(out_addr), 32'd0);
      check("arst_data", out_data, 32'd0);
      check("arst_last", 32'(out_last), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_rr", 32'(rr), 32'd0);
      repeat (2) tick();
      reset = 1'b1;
      repeat (10) tick();
      check("post_rst_busy", 32'(busy), 32'd0);
      check("post_rst_valid", 32'(out_valid), 32'd0);

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         tick();
         start     = ($urandom_range(0, 7) == 0);
         abort     = ($urandom_range(0, 29) == 0);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      tick();
      start = 1'b0; abort = 1'b0; out_ready = 1'b1;
      repeat (80) tick();

      // Short range instance: 28..31
      start2 = 1'b1;
      cyc = 0; w = 0; dc = -1;
      while (cyc < 40 && dc < 0) begin
         tick();
         cyc++;
         start2 = 1'b0;
         if (valid2) begin
            check("p_addr", 32'(addr2), 32'(28 + w));
            check("p_data", data2, rf[5'(28 + w)]);
            check("p_last", 32'(last2), 32'(w == 3));
            check("p_even_cycle", 32'(cyc % 2), 32'd0);
            w++;
         end
         if (done2) dc = cyc;
      end
      check("p_words", 32'(w), 32'd4);
      check("p_done_cycle", 32'(dc), 32'd9);
      tick();
      check("p_idle", 32'(busy2), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
